mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-port unified memory between the CPU instruction-fetch port and
//   the load/store port. Issues one access at a time, tracks the memory's fixed read
//   latency and routes the response back to the requester that won. Data accesses win
//   by default; a streak limit guarantees fetch forward progress.
// PARAMETERS
//   ADDR_W       32  byte-address width on all ports
//   DATA_W       32  data width; strobe width is DATA_W/8
//   MEM_LAT      2   cycles from grant (memory samples request) to response; >= 1
//   MAX_D_STREAK 4   max consecutive data grants while fetch waits; >= 1
// PORTS
//   clk       in   1         clock, all state updates on rising edge
//   rst       in   1         synchronous, active-high reset
//   if_req    in   1         fetch request; held stable until if_gnt
//   if_addr   in   ADDR_W    fetch address
//   if_gnt    out  1         fetch request accepted this cycle
//   if_rvalid out  1         fetch response valid (1-cycle pulse)
//   if_rdata  out  DATA_W    fetch data, valid with if_rvalid
//   d_req     in   1         load/store request; held stable until d_gnt
//   d_we      in   1         1 = store, 0 = load
//   d_addr    in   ADDR_W    data address
//   d_wdata   in   DATA_W    store data
//   d_wstrb   in   DATA_W/8  store byte enables
//   d_gnt     out  1         data request accepted this cycle
//   d_rvalid  out  1         data response (load data or store ack), 1-cycle pulse
//   d_rdata   out  DATA_W    load data, valid with d_rvalid; don't-care for stores
//   m_req     out  1         memory request strobe
//   m_we,m_addr,m_wdata,m_wstrb out  memory request fields (winner's fields; 0 when idle)
//   m_rdata   in   DATA_W    memory read data, valid MEM_LAT cycles after m_req
// BEHAVIOUR
//   - States IDLE, BUSY. Counter lat_cnt (MEM_LAT-1 .. 0), owner flag (FETCH/DATA),
//     streak counter d_streak (0..MAX_D_STREAK).
//   - Grant window: state==IDLE, or BUSY with lat_cnt==0 (response cycle). In a grant
//     window with any request: exactly one gnt asserted combinationally, m_req=1 and
//     m_* = winner's fields same cycle; next state BUSY, lat_cnt=MEM_LAT-1, owner=winner.
//     No request in a grant window -> IDLE, m_req=0, m_* driven 0.
//   - Arbitration: only d_req -> data; only if_req -> fetch; both -> data unless
//     d_streak==MAX_D_STREAK, then fetch.
//   - d_streak: data grant with if_req=1 -> +1 (saturating); data grant with if_req=0
//     -> 0; fetch grant -> 0; no grant -> hold.
//   - BUSY, lat_cnt>0: decrement; no gnt, m_req=0.
//   - BUSY, lat_cnt==0: owner's rvalid=1, owner's rdata=m_rdata; other rvalid=0.
//     New grant allowed in the same cycle (back-to-back, one access per MEM_LAT cycles).
//   - Latency: request in grant window at cycle T -> rvalid at cycle T+MEM_LAT.
//   - if_rdata/d_rdata: combinational pass of m_rdata; only meaningful with rvalid.
//   - Never: both gnt in one cycle; gnt while BUSY with lat_cnt>0; rvalid with no
//     access outstanding; two outstanding accesses.
//   - Reset: state IDLE, lat_cnt 0, d_streak 0, owner FETCH; all gnt, rvalid, m_req,
//     m_we, m_wstrb = 0 in the reset cycle and the next cycle's outputs reflect IDLE.
//     Reset mid-access drops the in-flight response: no rvalid is ever produced for it.
//   - Requests deasserted before gnt are legal and simply not serviced.
//   - Addresses passed unmodified; alignment checking is the requester's job.
// TESTING
//   1 Reset: rst=1 two cycles with if_req=d_req=1 -> no gnt, m_req=0, rvalid=0 throughout.
//   2 Lone fetch, MEM_LAT=2: if_req, if_addr=0x40 at T -> if_gnt,m_req,m_addr=0x40 at T;
//     if_rvalid at T+2 with if_rdata=m_rdata; d_rvalid stays 0.
//   3 Store: d_req,d_we=1,d_addr=0x100,d_wdata=0xDEADBEEF,d_wstrb=0xF -> m_* match at
//     gnt cycle; d_rvalid pulse 2 cycles later; following load of 0x100 returns 0xDEADBEEF.
//   4 Contention, MAX_D_STREAK=4: if_req and d_req held high continuously -> grant
//     order D,D,D,D,F,D,D,D,D,F...; one grant every MEM_LAT cycles; never two gnts.
//   5 Back-to-back: d_req held, 3 loads -> grants at T,T+2,T+4, rvalids at T+2,T+4,T+6.
//   6 Reset mid-access: grant at T, rst=1 at T+1 -> no rvalid at T+2; IDLE afterwards,
//     next request granted in first cycle after rst drops.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store,
// keeping one access in flight and steering the fixed-latency response to its owner.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 2,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_wstrb,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  m_req,
  output logic                  m_we,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  input  logic [DATA_W-1:0]     m_rdata,
  output logic                  fsm_state
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STK_W = $clog2(MAX_D_STREAK + 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             state_q;
  logic [LAT_W-1:0]   lat_cnt;
  logic               owner_d;
  logic [STK_W-1:0]   d_streak;

  logic grant_win;
  logic win_d;
  logic win_f;
  logic resp;

  // Handshake: a request is held until its gnt; gnt is the single-cycle accept,
  // and rvalid is a single-cycle pulse exactly MEM_LAT cycles after that accept.
  always_comb begin
    grant_win = !rst && (state_q == IDLE || lat_cnt == '0);
    win_d     = grant_win && d_req &&
                (!if_req || d_streak != STK_W'(MAX_D_STREAK));
    win_f     = grant_win && if_req && !win_d;
    resp      = !rst && state_q == BUSY && lat_cnt == '0;
  end

  assign if_gnt    = win_f;
  assign d_gnt     = win_d;
  assign if_rvalid = resp && !owner_d;
  assign d_rvalid  = resp && owner_d;
  assign if_rdata  = m_rdata;
  assign d_rdata   = m_rdata;
  assign fsm_state = state_q;

  always_comb begin
    m_req   = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_wstrb = '0;
    if (win_d) begin
      m_req   = 1'b1;
      m_we    = d_we;
      m_addr  = d_addr;
      m_wdata = d_wdata;
      m_wstrb = d_wstrb;
    end else if (win_f) begin
      m_req   = 1'b1;
      m_addr  = if_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      lat_cnt  <= '0;
      owner_d  <= 1'b0;
      d_streak <= '0;
    end else if (win_d || win_f) begin
      state_q <= BUSY;
      lat_cnt <= LAT_W'(MEM_LAT - 1);
      owner_d <= win_d;
      // The streak only grows while fetch is actually being held off.
      if (win_f || !if_req)
        d_streak <= '0;
      else if (d_streak != STK_W'(MAX_D_STREAK))
        d_streak <= d_streak + 1'b1;
    end else if (grant_win) begin
      state_q <= IDLE;
    end else begin
      lat_cnt <= lat_cnt - 1'b1;
    end
  end

endmodule
